// File: rtl/encoder_bank_if.sv
// Signal bundle for encoder_bank: raw encoder pins and per-channel controls in, positions/velocity/flags out.
// Defining ENCODER_INDEX_EN adds the per-channel index input quad_i and the index_hit output.
interface encoder_bank_if #(
    parameter int NUM_CH  = 2,
    parameter int COUNT_W = 24,
    parameter int VEL_W   = 16
);
    logic [NUM_CH-1:0]         quad_a;
    logic [NUM_CH-1:0]         quad_b;
    logic [NUM_CH-1:0]         zero_req;
    logic [NUM_CH-1:0]         err_clr;
    logic [NUM_CH*COUNT_W-1:0] count;
    logic [NUM_CH*VEL_W-1:0]   velocity;
    logic                      vel_valid;
    logic [NUM_CH-1:0]         err;
`ifdef ENCODER_INDEX_EN
    logic [NUM_CH-1:0]         quad_i;
    logic [NUM_CH-1:0]         index_hit;

    modport master (
        output quad_a, quad_b, quad_i, zero_req, err_clr,
        input  count, velocity, vel_valid, err, index_hit
    );
    modport slave (
        input  quad_a, quad_b, quad_i, zero_req, err_clr,
        output count, velocity, vel_valid, err, index_hit
    );
`else
    modport master (
        output quad_a, quad_b, zero_req, err_clr,
        input  count, velocity, vel_valid, err
    );
    modport slave (
        input  quad_a, quad_b, zero_req, err_clr,
        output count, velocity, vel_valid, err
    );
`endif
endinterface

// File: rtl/encoder_bank.sv
// Multi-channel quadrature front end: sync + deglitch A/B, signed position, sticky illegal-step flag, windowed velocity.
// Optional index input and index_hit pulse are compiled in with ENCODER_INDEX_EN.
module encoder_bank #(
    parameter int NUM_CH     = 2,
    parameter int COUNT_W    = 24,
    parameter int FILTER_LEN = 4,
    parameter int VEL_W      = 16,
    parameter int VEL_PERIOD = 32000
) (
    input logic           clk,
    input logic           reset,
    encoder_bank_if.slave bus
);
`ifdef ENCODER_INDEX_EN
    localparam int NSIG = 3;
`else
    localparam int NSIG = 2;
`endif
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WCW = $clog2(VEL_PERIOD);
    localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

    // Signal planes: [0] = A, [1] = B, [2] = I (index build only)
    logic [NSIG-1:0][NUM_CH-1:0] raw, sync1, sync2, filt;
    logic [FCW-1:0]              fcnt [NSIG][NUM_CH];
    logic [NUM_CH-1:0]           prev_a, prev_b;
    logic [NUM_CH-1:0]           up, dn, bad, clr;
    logic [1:0]                  diff;
    logic signed [COUNT_W-1:0]   cnt [NUM_CH];
    logic signed [VEL_W-1:0]     acc [NUM_CH];
    logic signed [VEL_W-1:0]     vel [NUM_CH];
    logic [NUM_CH-1:0]           err_q;
    logic                        vel_valid_q;
    logic [WCW-1:0]              wcnt;
    logic                        win_end;
`ifdef ENCODER_INDEX_EN
    logic [NUM_CH-1:0]           prev_i;
    logic [NUM_CH-1:0]           hit_q;
`endif

    always_comb begin
        raw    = '0;
        raw[0] = bus.quad_a;
        raw[1] = bus.quad_b;
`ifdef ENCODER_INDEX_EN
        raw[2] = bus.quad_i;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int unsigned s = 0; s < NSIG; s++)
                for (int unsigned n = 0; n < NUM_CH; n++)
                    fcnt[s][n] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned s = 0; s < NSIG; s++) begin
                for (int unsigned n = 0; n < NUM_CH; n++) begin
                    if (sync2[s][n] == filt[s][n]) begin
                        fcnt[s][n] <= '0;
                    end else if (fcnt[s][n] == FCW'(FILTER_LEN - 1)) begin
                        filt[s][n] <= sync2[s][n];
                        fcnt[s][n] <= '0;
                    end else begin
                        fcnt[s][n] <= fcnt[s][n] + 1'b1;
                    end
                end
            end
        end
    end

    // Gray {A,B} -> phase index {A, A^B}; the phase difference mod 4 gives the step
    always_comb begin
        up   = '0;
        dn   = '0;
        bad  = '0;
        diff = '0;
        clr  = bus.zero_req;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            diff   = {filt[0][n], filt[0][n] ^ filt[1][n]} - {prev_a[n], prev_a[n] ^ prev_b[n]};
            up[n]  = (diff == 2'b01);
            dn[n]  = (diff == 2'b11);
            bad[n] = (diff == 2'b10);
        end
`ifdef ENCODER_INDEX_EN
        clr = clr | (filt[2] & ~prev_i);
`endif
    end

    assign win_end = (wcnt == WCW'(VEL_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_a      <= '0;
            prev_b      <= '0;
            err_q       <= '0;
            vel_valid_q <= 1'b0;
            wcnt        <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                cnt[n] <= '0;
                acc[n] <= '0;
                vel[n] <= '0;
            end
        end else begin
            prev_a      <= filt[0];
            prev_b      <= filt[1];
            vel_valid_q <= win_end;
            wcnt        <= win_end ? '0 : wcnt + 1'b1;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (clr[n])
                    cnt[n] <= '0;
                else if (up[n])
                    cnt[n] <= cnt[n] + COUNT_W'(1);
                else if (dn[n])
                    cnt[n] <= cnt[n] - COUNT_W'(1);

                if (bad[n])
                    err_q[n] <= 1'b1;
                else if (bus.err_clr[n])
                    err_q[n] <= 1'b0;

                // Window close: publish the sum so far, this cycle's step opens the next window
                if (win_end) begin
                    vel[n] <= acc[n];
                    acc[n] <= up[n] ? VEL_W'(1) : (dn[n] ? '1 : '0);
                end else if (up[n] && acc[n] != VEL_MAX) begin
                    acc[n] <= acc[n] + VEL_W'(1);
                end else if (dn[n] && acc[n] != VEL_MIN) begin
                    acc[n] <= acc[n] - VEL_W'(1);
                end
            end
        end
    end

`ifdef ENCODER_INDEX_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_i <= '0;
            hit_q  <= '0;
        end else begin
            prev_i <= filt[2];
            hit_q  <= filt[2] & ~prev_i;
        end
    end
`endif

    always_comb begin
        bus.count    = '0;
        bus.velocity = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            bus.count[n*COUNT_W +: COUNT_W] = cnt[n];
            bus.velocity[n*VEL_W +: VEL_W]  = vel[n];
        end
        bus.vel_valid = vel_valid_q;
        bus.err       = err_q;
`ifdef ENCODER_INDEX_EN
        bus.index_hit = hit_q;
`endif
    end
endmodule

// File: tb/tb_encoder_bank.sv
// Directed + randomized bench for encoder_bank: a wide-velocity instance and a VEL_W=4 instance share stimulus.
// Expected counts/velocities come from a step log keyed by the edge on which each step takes effect.
module tb_encoder_bank;
    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int FL  = 4;
    localparam int VW  = 16;
    localparam int SVW = 4;
    localparam int P   = 100;
    localparam int NW  = 128;
    localparam int LAT = FL + 3;
    localparam int SMAX = 2 ** (SVW - 1) - 1;
    localparam int SMIN = -(2 ** (SVW - 1));

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    encoder_bank_if #(.NUM_CH(NCH), .COUNT_W(CW), .VEL_W(VW))  bus ();
    encoder_bank_if #(.NUM_CH(NCH), .COUNT_W(CW), .VEL_W(SVW)) sbus ();

    assign sbus.quad_a   = bus.quad_a;
    assign sbus.quad_b   = bus.quad_b;
    assign sbus.zero_req = bus.zero_req;
    assign sbus.err_clr  = bus.err_clr;
`ifdef ENCODER_INDEX_EN
    assign sbus.quad_i   = bus.quad_i;
`endif

    encoder_bank #(.NUM_CH(NCH), .COUNT_W(CW), .FILTER_LEN(FL), .VEL_W(VW), .VEL_PERIOD(P))
        u_dut (.clk(clk), .reset(reset), .bus(bus));
    encoder_bank #(.NUM_CH(NCH), .COUNT_W(CW), .FILTER_LEN(FL), .VEL_W(SVW), .VEL_PERIOD(P))
        u_sat (.clk(clk), .reset(reset), .bus(sbus));

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt  = 0;
    bit armed = 1'b0;
    int pos       [NCH];
    int model_cnt [NCH];
    int win_sum   [NCH][NW];
    int win_sat   [NCH][NW];

    // Edge index since reset release: edge 1 is the first edge with reset low
    always @(posedge clk) ecnt <= reset ? 0 : ecnt + 1;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] cnt_of(input int ch);
        return $signed(bus.count[ch*CW +: CW]);
    endfunction

    function automatic logic signed [31:0] vel_of(input int ch);
        return $signed(bus.velocity[ch*VW +: VW]);
    endfunction

    function automatic logic signed [31:0] svel_of(input int ch);
        return $signed(sbus.velocity[ch*SVW +: SVW]);
    endfunction

    function automatic logic signed [31:0] wrapc(input int v);
        logic signed [CW-1:0] t;
        t = v[CW-1:0];
        return t;
    endfunction

    function automatic int sat_add(input int a, input int d);
        int s;
        s = a + d;
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input int ch);
        logic [1:0] ab;
        case (pos[ch])
            0:       ab = 2'b00;
            1:       ab = 2'b01;
            2:       ab = 2'b11;
            default: ab = 2'b10;
        endcase
        bus.quad_a[ch] = ab[1];
        bus.quad_b[ch] = ab[0];
    endtask

    // One legal quadrature step; it lands on the count LAT edges from now
    task automatic drive(input int ch, input int d);
        int w;
        pos[ch] = (pos[ch] + d + 4) % 4;
        set_pins(ch);
        model_cnt[ch] += d;
        w = (ecnt + LAT) / P;
        if (w < NW) begin
            win_sum[ch][w] += d;
            win_sat[ch][w] = sat_add(win_sat[ch][w], d);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("vel_valid", bus.vel_valid, (ecnt > 0 && ecnt % P == 0));
            check("sat_vel_valid", sbus.vel_valid, (ecnt > 0 && ecnt % P == 0));
            if (ecnt > 0 && ecnt % P == 0 && ecnt / P - 1 < NW) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    check("velocity", vel_of(ch), win_sum[ch][ecnt/P-1]);
                    check("sat_velocity", svel_of(ch), win_sat[ch][ecnt/P-1]);
                end
            end
        end
    end

    initial begin
        int base;
        bus.quad_a   = '0;
        bus.quad_b   = '0;
        bus.zero_req = '0;
        bus.err_clr  = '0;
`ifdef ENCODER_INDEX_EN
        bus.quad_i   = '0;
`endif
        tick(3);
        for (int ch = 0; ch < NCH; ch++) begin
            check("reset_count", cnt_of(ch), 0);
            check("reset_velocity", vel_of(ch), 0);
        end
        check("reset_vel_valid", bus.vel_valid, 0);
        check("reset_err", bus.err, 0);
        reset = 1'b0;
        armed = 1'b1;

        // 10 forward cycles on ch0, 8 cycles per phase
        for (int i = 0; i < 40; i++) begin
            drive(0, 1);
            tick(8);
        end
        tick(4);
        check("fwd40_ch0", cnt_of(0), 40);
        check("fwd40_ch1", cnt_of(1), 0);
        check("fwd40_err", bus.err, 0);

        // 3-cycle glitch on A of ch1 must vanish
        base = model_cnt[1];
        bus.quad_a[1] = 1'b1;
        tick(3);
        set_pins(1);
        tick(10);
        check("glitch_count", cnt_of(1), wrapc(base));
        check("glitch_err", bus.err[1], 0);

        // 5-cycle pulse: -1 lands on edge 7, the return +1 on edge 12
        drive(1, -1);
        tick(5);
        drive(1, 1);
        tick(1);
        check("lat_edge6", cnt_of(1), wrapc(base));
        tick(1);
        check("lat_edge7", cnt_of(1), wrapc(base - 1));
        tick(5);
        check("lat_edge12", cnt_of(1), wrapc(base));

        // Illegal 00->11 on ch0
        pos[0] = 2;
        set_pins(0);
        tick(10);
        check("illegal_err0", bus.err[0], 1);
        check("illegal_err1", bus.err[1], 0);
        check("illegal_count", cnt_of(0), wrapc(model_cnt[0]));
        bus.err_clr[0] = 1'b1;
        tick(1);
        bus.err_clr[0] = 1'b0;
        check("err_clear", bus.err[0], 0);

        // Illegal 11->00 coinciding with err_clr: set wins
        pos[0] = 0;
        set_pins(0);
        tick(LAT - 1);
        check("pre_illegal_err", bus.err[0], 0);
        bus.err_clr[0] = 1'b1;
        tick(1);
        bus.err_clr[0] = 1'b0;
        check("set_beats_clr", bus.err[0], 1);
        check("set_beats_clr_count", cnt_of(0), 40);
        bus.err_clr[0] = 1'b1;
        tick(1);
        bus.err_clr[0] = 1'b0;
        check("err_clear2", bus.err[0], 0);

        // zero_req on the same edge as a step: count 0, step only counted in velocity
        drive(0, 1);
        tick(LAT - 1);
        bus.zero_req[0] = 1'b1;
        tick(1);
        bus.zero_req[0] = 1'b0;
        model_cnt[0] = 0;
        check("zero_with_step", cnt_of(0), 0);
        check("zero_other_ch", cnt_of(1), wrapc(model_cnt[1]));

        // Climb to +max then wrap
        for (int i = 0; i < 127; i++) begin
            drive(0, 1);
            tick(5);
        end
        tick(LAT);
        check("count_max", cnt_of(0), 127);
        drive(0, 1);
        tick(LAT + 1);
        check("count_wrap", cnt_of(0), -128);
        check("count_wrap_model", cnt_of(0), wrapc(model_cnt[0]));

        // Velocity: 10/window forward, 10/window reverse, 20/window forward on ch1
        for (int i = 0; i < 35; i++) begin
            drive(1, 1);
            tick(10);
        end
        check("vel_fwd10", vel_of(1), 10);
        check("sat_fwd10", svel_of(1), SMAX);
        for (int i = 0; i < 35; i++) begin
            drive(1, -1);
            tick(10);
        end
        check("vel_rev10", vel_of(1), -10);
        check("sat_rev10", svel_of(1), SMIN);
        for (int i = 0; i < 45; i++) begin
            drive(1, 1);
            tick(5);
        end
        check("vel_fwd20", vel_of(1), 20);
        check("sat_fwd20", svel_of(1), SMAX);

        // Randomized legal steps across both channels
        for (int i = 0; i < 60; i++) begin
            drive(int'($urandom_range(0, NCH - 1)), ($urandom_range(0, 1) == 1) ? 1 : -1);
            tick(int'($urandom_range(FL + 1, 12)));
        end
        tick(LAT + 5);
        for (int ch = 0; ch < NCH; ch++)
            check("random_count", cnt_of(ch), wrapc(model_cnt[ch]));
        check("random_err", bus.err, 0);

`ifdef ENCODER_INDEX_EN
        bus.quad_i[0] = 1'b1;
        tick(LAT - 1);
        check("index_pre", bus.index_hit, 0);
        tick(1);
        model_cnt[0] = 0;
        check("index_hit", bus.index_hit, 1);
        check("index_count", cnt_of(0), 0);
        tick(1);
        check("index_pulse_end", bus.index_hit, 0);
        bus.quad_i[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1);
            tick(6);
        end
        tick(LAT);
        check("index_recount", cnt_of(0), 3);
        check("index_ch1", cnt_of(1), wrapc(model_cnt[1]));
`endif

        tick(P + 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/encoder_bank.md
# encoder_bank

Parametrised multi-channel quadrature encoder front end for the motor board, replacing the per-encoder fixed counters instantiated at top level. It synchronises and deglitches NUM_CH A/B pairs, maintains a signed position count per channel, flags illegal transitions, and produces a windowed velocity per channel. It sits between the encoder pins and the displacement, control and coms logic in the 32 MHz domain.

## Interface
- NUM_CH, 2, number of encoder channels
- COUNT_W, 24, signed position width per channel
- FILTER_LEN, 4, consecutive equal samples required to accept a pin level (≥1)
- VEL_W, 16, signed velocity width per channel
- VEL_PERIOD, 32000, clock cycles per velocity window (1 ms at 32 MHz, ≥2)

- clk  in  1  system clock (32 MHz PLL output)
- reset  in  1  synchronous, active-high
- quad_a  in  NUM_CH  raw A inputs, asynchronous
- quad_b  in  NUM_CH  raw B inputs, asynchronous
- zero_req  in  NUM_CH  per-channel synchronous count clear, level-sampled each cycle
- err_clr  in  NUM_CH  per-channel clear of sticky error flag
- count  out  NUM_CH*COUNT_W  signed positions; channel n at [n*COUNT_W +: COUNT_W]
- velocity  out  NUM_CH*VEL_W  signed counts per window; channel n at [n*VEL_W +: VEL_W]
- vel_valid  out  1  one-cycle pulse when velocity updates (all channels together)
- err  out  NUM_CH  sticky illegal-transition flag

## Operation
- Per channel: 2-FF synchroniser on A and B, then independent filter per signal: filtered level changes only after FILTER_LEN consecutive synchronised samples differ from current filtered level; filtered levels reset to 0.
- Decoder compares current filtered {A,B} with registered previous: 00→01→11→10→00 is +1, reverse is −1, no change is 0, both bits changing is illegal: step 0, err[n] set.
- err[n]: set wins over err_clr[n] in the same cycle; otherwise err_clr[n] clears it.
- count[n] wraps two's-complement (0x7FFFFF +1 → 0x800000 for COUNT_W=24).
- zero_req[n] high: count[n] ← 0; any same-cycle step is discarded from count but still enters velocity accumulator.
- Velocity: shared window counter 0..VEL_PERIOD−1; per-channel accumulator of steps, saturating at ±(2^(VEL_W−1)−1 / −2^(VEL_W−1)). At counter = VEL_PERIOD−1: velocity[n] ← accumulator (excluding this cycle's step), accumulator ← this cycle's step, vel_valid ← 1 for one cycle.
- zero_req and err_clr do not affect window counter or accumulators.
- Reset values: count 0, velocity 0, vel_valid 0, err 0, window counter 0, accumulators 0, previous-state registers 00.

## Timing
- Pin-to-count latency: FILTER_LEN+3 clock edges from the first edge sampling a new stable pin level (2 sync, FILTER_LEN filter, 1 decode/count).
- Maximum trackable rate: each quadrature phase stable ≥ FILTER_LEN+1 cycles; pulses shorter than FILTER_LEN cycles are rejected entirely.
- First vel_valid: VEL_PERIOD edges after reset deasserts, then every VEL_PERIOD cycles.
- zero_req effect visible on count the edge after sampling.
- Reset asserted mid-window or mid-transition: all state returns to reset values on that edge; a pin level ≠ 00 at reset release is absorbed as ordinary transitions (may count ±1 or flag err on the first decode).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- ENCODER_INDEX_EN defined: adds input quad_i [NUM_CH] (synchronised and filtered like A/B) and output index_hit [NUM_CH]; on filtered rising edge of I, count[n] ← 0 (same priority as zero_req, step discarded from count) and index_hit[n] pulses one cycle. Reset value index_hit 0.
- Not defined: ports quad_i and index_hit absent; no index logic.

## Test plan
- Reset, then 10 forward cycles on ch0 (40 edges, phases 8 cycles each, FILTER_LEN=4) → count ch0 = 40, ch1 = 0, err = 0.
- 3-cycle glitch on quad_a[1] → count ch1 unchanged, err[1] = 0; 5-cycle level → step registered exactly 7 edges after first sampling edge.
- Simultaneous A and B toggle on ch0 → count unchanged, err[0] = 1 until err_clr[0]; err_clr coincident with new illegal transition → err stays 1.
- Count preset near +max via 8388607 steps (or forced COUNT_W=8: 127) then +1 → wraps to −max−1; zero_req with concurrent step → count 0.
- VEL_PERIOD=100, steady +1 step every 10 cycles → vel_valid every 100 cycles, velocity = 10; reverse direction → −10; VEL_W=4 with 20 steps/window → velocity saturates at 7.
- ENCODER_INDEX_EN build: count 57, index rising edge → count 0 and index_hit one-cycle pulse, subsequent steps count from 0.
